// File: rtl/alarm_mode_ctrl.sv
// Alarm clock central controller: arbitrates button pulses, sequences the mode FSM,
// keeps time-of-day and alarm registers, and drives the ring output with auto-stop.
module alarm_mode_ctrl #(
  parameter int unsigned RING_SECS = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_c,
  input  logic       btn_r,
  input  logic       btn_l,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       sec_tick,
  output logic [2:0] mode,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [4:0] a_hour,
  output logic [5:0] a_min,
  output logic       alarm_en,
  output logic       alarm_ring
);

  typedef enum logic [2:0] {
    CLOCK     = 3'd0,
    ADJ_HOUR  = 3'd1,
    ADJ_MIN   = 3'd2,
    ADJ_AHOUR = 3'd3,
    ADJ_AMIN  = 3'd4
  } mode_e;

  localparam logic [7:0] RING_LAST = 8'(RING_SECS - 1);

  mode_e      mode_q, mode_d;
  logic [4:0] hour_q, hour_d, ahour_q, ahour_d;
  logic [5:0] min_q, min_d, sec_q, sec_d, amin_q, amin_d;
  logic       en_q, en_d, ring_q, ring_d;
  logic [7:0] cnt_q, cnt_d;
  logic       p_c, p_r, p_l, p_u, p_d, press, run;

  // Fixed priority c > r > l > u > d; losers are dropped.
  assign p_c   = btn_c;
  assign p_r   = btn_r & ~btn_c;
  assign p_l   = btn_l & ~btn_c & ~btn_r;
  assign p_u   = btn_u & ~btn_c & ~btn_r & ~btn_l;
  assign p_d   = btn_d & ~btn_c & ~btn_r & ~btn_l & ~btn_u;
  assign press = btn_c | btn_r | btn_l | btn_u | btn_d;
  assign run   = sec_tick && (mode_q != ADJ_HOUR) && (mode_q != ADJ_MIN);

  always_comb begin
    mode_d  = mode_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    ahour_d = ahour_q;
    amin_d  = amin_q;
    en_d    = en_q;
    ring_d  = ring_q;
    cnt_d   = cnt_q;

    if (run) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    if (ring_q) begin
      if (press) begin
        ring_d = 1'b0;
        cnt_d  = 8'd0;
      end else if (sec_tick) begin
        if (cnt_q == RING_LAST) begin
          ring_d = 1'b0;
          cnt_d  = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    end else begin
      case (mode_q)
        CLOCK: begin
          if (p_c)      mode_d = ADJ_HOUR;
          else if (p_u) en_d   = ~en_q;
        end
        default: begin
          if (p_c)      mode_d = CLOCK;
          else if (p_r) mode_d = (mode_q == ADJ_AMIN) ? ADJ_HOUR : mode_e'(mode_q + 3'd1);
          else if (p_l) mode_d = (mode_q == ADJ_HOUR) ? ADJ_AMIN : mode_e'(mode_q - 3'd1);
          else if (p_u || p_d) begin
            // Time fields are only edited while frozen, so no clash with the tick cascade.
            case (mode_q)
              ADJ_HOUR: begin
                if (p_u) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                else     hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
                sec_d = 6'd0;
              end
              ADJ_MIN: begin
                if (p_u) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                else     min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
                sec_d = 6'd0;
              end
              ADJ_AHOUR: begin
                if (p_u) ahour_d = (ahour_q == 5'd23) ? 5'd0 : ahour_q + 5'd1;
                else     ahour_d = (ahour_q == 5'd0) ? 5'd23 : ahour_q - 5'd1;
              end
              ADJ_AMIN: begin
                if (p_u) amin_d = (amin_q == 6'd59) ? 6'd0 : amin_q + 6'd1;
                else     amin_d = (amin_q == 6'd0) ? 6'd59 : amin_q - 6'd1;
              end
              default: ;
            endcase
          end
        end
      endcase

      if (run && en_q && hour_d == ahour_q && min_d == amin_q && sec_d == 6'd0)
        ring_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q  <= CLOCK;
      hour_q  <= 5'd0;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      ahour_q <= 5'd0;
      amin_q  <= 6'd0;
      en_q    <= 1'b0;
      ring_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      mode_q  <= mode_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      ahour_q <= ahour_d;
      amin_q  <= amin_d;
      en_q    <= en_d;
      ring_q  <= ring_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mode       = mode_q;
  assign hour       = hour_q;
  assign minute     = min_q;
  assign second     = sec_q;
  assign a_hour     = ahour_q;
  assign a_min      = amin_q;
  assign alarm_en   = en_q;
  assign alarm_ring = ring_q;

endmodule

// File: tb/tb_alarm_mode_ctrl.sv
// Bench for alarm_mode_ctrl: directed scenarios then random presses/ticks,
// every cycle compared against a seconds-of-day reference model.
module tb_alarm_mode_ctrl;

  localparam int RS = 3;
  localparam logic [4:0] N = 5'b00000, C = 5'b10000, R = 5'b01000,
                         L = 5'b00100, U = 5'b00010, D = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_c = 1'b0, btn_r = 1'b0, btn_l = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
  logic       sec_tick = 1'b0;
  logic [2:0] mode;
  logic [4:0] hour, a_hour;
  logic [5:0] minute, second, a_min;
  logic       alarm_en, alarm_ring;

  int vectors = 0;
  int miscompares = 0;

  // Model state: mode number, time as seconds of day, alarm as minutes of day.
  int m_mode, m_t, m_am, m_cnt;
  bit m_en, m_ring;

  alarm_mode_ctrl #(.RING_SECS(RS)) dut (
    .clk(clk), .rst(rst),
    .btn_c(btn_c), .btn_r(btn_r), .btn_l(btn_l), .btn_u(btn_u), .btn_d(btn_d),
    .sec_tick(sec_tick),
    .mode(mode), .hour(hour), .minute(minute), .second(second),
    .a_hour(a_hour), .a_min(a_min), .alarm_en(alarm_en), .alarm_ring(alarm_ring)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rs, input bit [4:0] b, input bit tk);
    int p, h, mi, delta;
    bit run, trig;
    if (rs) begin
      m_mode = 0; m_t = 0; m_am = 0; m_cnt = 0; m_en = 0; m_ring = 0;
      return;
    end
    p = b[4] ? 1 : b[3] ? 2 : b[2] ? 3 : b[1] ? 4 : b[0] ? 5 : 0;
    run = tk && m_mode != 1 && m_mode != 2;
    if (run) m_t = (m_t + 1) % 86400;
    trig = run && m_en && !m_ring && (m_t == m_am * 60);
    if (m_ring) begin
      if (p != 0) begin
        m_ring = 0; m_cnt = 0;
      end else if (tk) begin
        m_cnt++;
        if (m_cnt == RS) begin m_ring = 0; m_cnt = 0; end
      end
    end else begin
      if (m_mode == 0) begin
        if (p == 1)      m_mode = 1;
        else if (p == 4) m_en = !m_en;
      end else if (p == 1) m_mode = 0;
      else if (p == 2) m_mode = m_mode % 4 + 1;
      else if (p == 3) m_mode = (m_mode + 2) % 4 + 1;
      else if (p == 4 || p == 5) begin
        delta = (p == 4) ? 1 : -1;
        h  = m_t / 3600;
        mi = (m_t / 60) % 60;
        case (m_mode)
          1: m_t = ((h + delta + 24) % 24) * 3600 + mi * 60;
          2: m_t = h * 3600 + ((mi + delta + 60) % 60) * 60;
          3: m_am = ((m_am / 60 + delta + 24) % 24) * 60 + m_am % 60;
          default: m_am = (m_am / 60) * 60 + (m_am % 60 + delta + 60) % 60;
        endcase
      end
      if (trig) m_ring = 1;
    end
  endtask

  task automatic step(input bit rs, input bit [4:0] b, input bit tk);
    rst = rs;
    {btn_c, btn_r, btn_l, btn_u, btn_d} = b;
    sec_tick = tk;
    @(posedge clk);
    model_step(rs, b, tk);
    #1;
    chk("mode",   int'(mode),       m_mode);
    chk("hour",   int'(hour),       m_t / 3600);
    chk("minute", int'(minute),     (m_t / 60) % 60);
    chk("second", int'(second),     m_t % 60);
    chk("a_hour", int'(a_hour),     m_am / 60);
    chk("a_min",  int'(a_min),      m_am % 60);
    chk("en",     int'(alarm_en),   int'(m_en));
    chk("ring",   int'(alarm_ring), int'(m_ring));
  endtask

  initial begin
    bit [4:0] rb;
    // Reset dominates a press and a tick.
    step(1, C, 1);
    chk("rst_mode", int'(mode), 0);
    chk("rst_hour", int'(hour), 0);
    chk("rst_ring", int'(alarm_ring), 0);
    chk("rst_en",   int'(alarm_en), 0);

    // Set 01:59:00 via adjust.
    step(0, C, 0);
    repeat (25) step(0, U, 0);
    step(0, R, 0);
    step(0, D, 0);
    step(0, C, 0);
    chk("adj_hour", int'(hour), 1);
    chk("adj_min",  int'(minute), 59);
    chk("adj_sec",  int'(second), 0);
    chk("adj_mode", int'(mode), 0);

    // Simultaneous c+u: centre wins, alarm_en untouched; wrap of left/right.
    step(0, C | U, 0);
    chk("arb_mode", int'(mode), 1);
    chk("arb_en",   int'(alarm_en), 0);
    step(0, L, 0);
    chk("wrap_l", int'(mode), 4);
    step(0, R, 0);
    chk("wrap_r", int'(mode), 1);

    // 23:59:58 then rollover; freeze in ADJ_HOUR.
    step(0, D, 0);
    step(0, D, 0);
    step(0, C, 0);
    repeat (58) step(0, N, 1);
    step(0, N, 1);
    chk("t_2359_h", int'(hour), 23);
    chk("t_2359_s", int'(second), 59);
    step(0, N, 1);
    chk("roll_h", int'(hour), 0);
    chk("roll_m", int'(minute), 0);
    chk("roll_s", int'(second), 0);
    step(0, C, 0);
    repeat (3) step(0, N, 1);
    chk("frz_s", int'(second), 0);
    chk("frz_m", int'(minute), 0);
    step(0, C, 0);

    // Alarm 07:30, armed; time 07:29:59.
    step(0, C, 0);
    step(0, R, 0);
    step(0, R, 0);
    repeat (7) step(0, U, 0);
    step(0, R, 0);
    repeat (30) step(0, U, 0);
    step(0, C, 0);
    step(0, U, 0);
    chk("armed", int'(alarm_en), 1);
    step(0, C, 0);
    repeat (7) step(0, U, 0);
    step(0, R, 0);
    repeat (31) step(0, D, 0);
    step(0, C, 0);
    repeat (59) step(0, N, 1);
    step(0, N, 1);
    chk("trig_ring", int'(alarm_ring), 1);
    step(0, D, 0);
    chk("stop_ring", int'(alarm_ring), 0);
    chk("stop_mode", int'(mode), 0);
    chk("stop_min",  int'(minute), 30);
    chk("stop_en",   int'(alarm_en), 1);

    // Retrigger and let it time out after RS ticks.
    step(0, C, 0);
    step(0, R, 0);
    step(0, D, 0);
    step(0, C, 0);
    repeat (59) step(0, N, 1);
    step(0, N, 1);
    chk("re_ring", int'(alarm_ring), 1);
    step(0, N, 1);
    step(0, N, 1);
    chk("to_ring2", int'(alarm_ring), 1);
    step(0, N, 1);
    chk("to_ring3", int'(alarm_ring), 0);
    chk("to_sec",   int'(second), 3);
    step(0, N, 1);
    chk("no_retrig", int'(alarm_ring), 0);

    // Random presses and ticks.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 5; k++) rb[k] = ($urandom_range(0, 5) == 0);
      step($urandom_range(0, 299) == 0, rb, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alarm_mode_ctrl.md
Name: alarm_mode_ctrl

Overview:
- Central controller for the alarm clock. It consumes the single-cycle button pulses produced by the per-button rising-edge detectors and a 1 Hz tick.
- It arbitrates simultaneous presses and sequences a mode FSM for display, time adjust and alarm adjust.
- It owns the time-of-day and alarm registers and drives the alarm ring output.
- It sits between the button edge detectors and the display/buzzer logic.

Parameters:
- RING_SECS, 60, number of sec_tick pulses the alarm rings before auto-stop (1..255).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn_c  in  1  centre-button pulse, one clk wide
- btn_r  in  1  right-button pulse
- btn_l  in  1  left-button pulse
- btn_u  in  1  up-button pulse
- btn_d  in  1  down-button pulse
- sec_tick  in  1  one-clk pulse, once per second
- mode  out  3  0=CLOCK 1=ADJ_HOUR 2=ADJ_MIN 3=ADJ_AHOUR 4=ADJ_AMIN
- hour  out  5  time hours, 0..23
- minute  out  6  time minutes, 0..59
- second  out  6  time seconds, 0..59
- a_hour  out  5  alarm hours, 0..23
- a_min  out  6  alarm minutes, 0..59
- alarm_en  out  1  alarm armed
- alarm_ring  out  1  buzzer drive

Behaviour:
- Reset (sync, active-high, on clk rising edge):
  - mode=CLOCK; hour, minute, second, a_hour, a_min all 0.
  - alarm_en=0, alarm_ring=0, ring counter 0.
  - rst overrides any pulse in the same cycle. Reset mid-adjust or mid-ring returns to this state on the next edge.
- All outputs are registered. An accepted press takes effect on the edge where it is sampled and is visible the following cycle.
- Arbitration: if several btn_* are high in one cycle, only the highest-priority one is accepted (c > r > l > u > d). The others are discarded, not queued.
- Ringing overrides everything:
  - While alarm_ring=1, any accepted press only clears alarm_ring and the ring counter.
  - That press has no other effect: mode, fields and alarm_en are unchanged.
- FSM in CLOCK:
  - btn_c -> ADJ_HOUR.
  - btn_u toggles alarm_en.
  - btn_r, btn_l, btn_d are ignored.
- FSM in adjust states (1..4):
  - btn_c -> CLOCK.
  - btn_r -> next adjust state (4 wraps to 1).
  - btn_l -> previous adjust state (1 wraps to 4).
  - btn_u increments the selected field; btn_d decrements it.
  - Field selection: ADJ_HOUR=hour, ADJ_MIN=minute, ADJ_AHOUR=a_hour, ADJ_AMIN=a_min.
  - Wrap rules: hours 23->0 and 0->23; minutes 59->0 and 0->59.
  - In ADJ_HOUR or ADJ_MIN, any btn_u or btn_d also clears second to 0.
- Timekeeping:
  - sec_tick advances second, minute and hour with cascaded wrap (23:59:59 -> 00:00:00).
  - Advances in CLOCK, ADJ_AHOUR and ADJ_AMIN.
  - Frozen in ADJ_HOUR and ADJ_MIN.
- Simultaneous sec_tick and press:
  - Both are applied in the same cycle; no tick is lost.
  - The freeze decision uses the mode before the edge, e.g. CLOCK + btn_c + tick: time advances and mode becomes ADJ_HOUR.
- Alarm trigger:
  - Condition: alarm_en=1, alarm_ring=0, and a sec_tick advances the time so that the new value has hour==a_hour, minute==a_min, second==0.
  - alarm_ring is set on that same edge. Evaluation uses the next-state time values.
  - The trigger also fires in adjust modes where time runs.
- Ring timeout:
  - Ring counter increments on each sec_tick while ringing.
  - On the RING_SECS-th tick, alarm_ring clears and the counter resets.
  - A press and the final tick in the same cycle both clear alarm_ring; the press has no other effect.
- Clearing alarm_en (only possible in CLOCK with btn_u while not ringing) cannot stop an active ring.

Test Plan:
- rst=1 with btn_c and sec_tick high -> all outputs 0, mode=0 on the following cycle.
- btn_c, btn_u ×25, btn_r, btn_d ×1, btn_c -> hour=1, minute=59, second=0, mode=0.
- btn_c and btn_u high in the same cycle in CLOCK -> mode=1, alarm_en stays 0. Then btn_l -> mode=4; btn_r -> mode=1.
- Set time 23:59:58 in CLOCK, 2 sec_ticks -> 23:59:59 then 00:00:00. In ADJ_HOUR, 3 sec_ticks -> time unchanged.
- a_hour=7, a_min=30, alarm_en=1, time 07:29:59, one sec_tick -> alarm_ring=1 the next cycle. btn_d pulse -> alarm_ring=0; mode, minute and alarm_en unchanged.
- RING_SECS=3, trigger the alarm, 3 sec_ticks with no press -> alarm_ring drops after the 3rd tick and does not re-trigger at 07:30:03.
